// File: rtl/seven_segment_capture.sv
// seven_segment_capture: reads back a scanned, multiplexed 7-segment bus.
// Each {seg,dig_sel} sample must stay unchanged for STABLE_CYCLES samples
// before it is committed to that digit's slot. The slot then holds either a
// decoded hex value, a blank marker, or raises an error for an unknown pattern.
// frame_done pulses once every digit has been committed at least once.
module seven_segment_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int SEG_ON        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     blank,
    output logic                  err,
    output logic [2:0]            err_digit,
    output logic                  frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {COLLECT = 1'b0} frame_state_t;

    logic [6:0]        seg_eff;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_q;
    logic [CW-1:0]     run_cnt;
    logic              same;
    logic              commit;
    logic [4:0]        dec;
    logic [2:0]        sel_idx;
    logic [DIGITS-1:0] mask_q, mask_n;
    frame_state_t      state_q, state_n;
    logic              frame_n;

    // Pattern table: {legal, value}. All-off and unknown patterns are not legal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E: decode = {1'b1, 4'h0};
            7'h30: decode = {1'b1, 4'h1};
            7'h6D: decode = {1'b1, 4'h2};
            7'h79: decode = {1'b1, 4'h3};
            7'h33: decode = {1'b1, 4'h4};
            7'h5B: decode = {1'b1, 4'h5};
            7'h5F: decode = {1'b1, 4'h6};
            7'h70: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h7B: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h1F: decode = {1'b1, 4'hB};
            7'h4E: decode = {1'b1, 4'hC};
            7'h3D: decode = {1'b1, 4'hD};
            7'h4F: decode = {1'b1, 4'hE};
            7'h47: decode = {1'b1, 4'hF};
            default: decode = 5'b0;
        endcase
    endfunction

    // Normalise segment polarity and compare the new sample with the held one.
    always_comb begin
        seg_eff = (SEG_ON != 0) ? seg : ~seg;
        same    = (seg_eff == seg_q) && (dig_sel == dig_q);
        // Run counter counts repeats after the first sample, so STABLE_CYCLES
        // identical samples are reached when it reads STABLE_CYCLES-1.
        commit  = (run_cnt == CW'(STABLE_CYCLES - 1)) && $onehot(dig_q);
        dec     = decode(seg_q);
    end

    // Index of the currently selected digit (dig_q is one-hot when used).
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dig_q[i]) sel_idx = 3'(i);
        end
    end

    // Input sample register and saturating stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= '0;
            dig_q   <= '0;
            run_cnt <= '0;
        end else begin
            seg_q <= seg_eff;
            dig_q <= dig_sel;
            if (same && $onehot(dig_q)) begin
                if (run_cnt != CW'(STABLE_CYCLES)) run_cnt <= run_cnt + 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

    // Per-digit result slots and error reporting on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out     <= '0;
            digit_valid <= '0;
            blank       <= '0;
            err         <= 1'b0;
            err_digit   <= '0;
        end else begin
            err <= 1'b0;
            if (commit) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (dig_q[i]) begin
                        if (dec[4]) begin
                            hex_out[4*i +: 4] <= dec[3:0];
                            digit_valid[i]    <= 1'b1;
                            blank[i]          <= 1'b0;
                        end else begin
                            digit_valid[i] <= 1'b0;
                            blank[i]       <= (seg_q == '0);
                        end
                    end
                end
                if (!dec[4] && (seg_q != '0)) begin
                    err       <= 1'b1;
                    err_digit <= sel_idx;
                end
            end
        end
    end

    // Frame tracking: the commit that completes the mask clears it in the same
    // step, so the next frame starts empty and re-commits never re-pulse.
    always_comb begin
        state_n = state_q;
        mask_n  = mask_q;
        frame_n = 1'b0;
        case (state_q)
            COLLECT: begin
                if (commit) begin
                    mask_n = mask_q | dig_q;
                    if (&mask_n) begin
                        frame_n = 1'b1;
                        mask_n  = '0;
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // Frame state, mask and frame_done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            mask_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            mask_q     <= mask_n;
            frame_done <= frame_n;
        end
    end

endmodule
